// File: rtl/data_loader_pkg.sv
// Shared definitions for the operand loader: FSM encoding and datapath defaults.
// COL_LAST matches the controller's final column compare.
package data_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } loader_state_e;

  localparam int NUM_WORDS_DEF = 8;
  localparam int WORD_W_DEF    = 32;
  localparam int ELEM_W_DEF    = 8;
  localparam logic [4:0] COL_LAST = 5'd28;

endpackage

// File: rtl/data_loader_regbank.sv
// Double-buffered operand storage: fill buffer written word by word, active buffer
// copied on commit (with the last word written through), and the byte-select mux.
module data_loader_regbank
  import data_loader_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int PTR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic              commit_i,
  input  logic [PTR_W-1:0]  wptr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [4:0]        col_i,
  output logic [ELEM_W-1:0] byte_o
);

  localparam int BYTES_PER_WORD = WORD_W / ELEM_W;
  localparam int BSEL_W         = $clog2(BYTES_PER_WORD);
  localparam int NUM_BYTES      = NUM_WORDS * BYTES_PER_WORD;

  logic [WORD_W-1:0] fill_q   [NUM_WORDS];
  logic [WORD_W-1:0] active_q [NUM_WORDS];
  logic [PTR_W-1:0]  word_idx_s;
  logic [BSEL_W-1:0] byte_idx_s;
  logic [WORD_W-1:0] word_s;

  assign word_idx_s = PTR_W'(col_i >> BSEL_W);
  assign byte_idx_s = col_i[BSEL_W-1:0];

  // Active buffer only changes on the commit edge, so in-flight fetches read the old vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        fill_q[i]   <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        fill_q[wptr_i] <= wdata_i;
      end
      if (commit_i) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          active_q[i] <= (PTR_W'(i) == wptr_i) ? wdata_i : fill_q[i];
        end
      end
    end
  end

  always_comb begin
    word_s = active_q[word_idx_s];
    byte_o = '0;
    if (int'(col_i) < NUM_BYTES) begin
      byte_o = word_s[ELEM_W*int'(byte_idx_s) +: ELEM_W];
    end else begin
      byte_o = '0;
    end
  end

endmodule

// File: rtl/data_loader.sv
// Operand loader top: bus write decode, fill pointer, IDLE/FILL/COMMIT sequencing
// and the registered element fetch toward the ALU.
module data_loader
  import data_loader_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int PTR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              alu_en,
  input  logic [4:0]        col_count,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [WORD_W-1:0] pwdata,
  output logic              load_done,
  output logic [ELEM_W-1:0] elem_out,
  output logic              elem_valid,
  output logic              wr_drop,
  output logic [PTR_W:0]    fill_level
);

  loader_state_e     state_q;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W:0]    fill_level_q;
  logic              load_done_q, wr_drop_q, elem_valid_q;
  logic [ELEM_W-1:0] elem_out_q;
  logic [ELEM_W-1:0] byte_s;
  logic              wr_s, accept_s, drop_s, last_s;

  // Writes landing during COMMIT are refused even with load_en still high.
  assign wr_s     = psel & penable & pwrite;
  assign accept_s = wr_s & load_en & (state_q != ST_COMMIT);
  assign drop_s   = wr_s & ~accept_s;
  assign last_s   = accept_s & (wptr_q == PTR_W'(NUM_WORDS - 1));

  always_comb begin
    wptr_d = wptr_q;
    if (last_s) begin
      wptr_d = '0;
    end else if (accept_s) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      fill_level_q <= '0;
      load_done_q  <= 1'b0;
      wr_drop_q    <= 1'b0;
      elem_valid_q <= 1'b0;
      elem_out_q   <= '0;
    end else begin
      wptr_q       <= wptr_d;
      fill_level_q <= last_s ? (PTR_W+1)'(NUM_WORDS) : {1'b0, wptr_d};
      load_done_q  <= last_s;
      wr_drop_q    <= drop_s;
      elem_valid_q <= alu_en;
      if (alu_en) begin
        elem_out_q <= byte_s;
      end
      case (state_q)
        ST_IDLE:   state_q <= last_s ? ST_COMMIT : (load_en ? ST_FILL : ST_IDLE);
        ST_FILL:   state_q <= last_s ? ST_COMMIT : (load_en ? ST_FILL : ST_IDLE);
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  data_loader_regbank #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W),
    .ELEM_W    (ELEM_W),
    .PTR_W     (PTR_W)
  ) u_regbank (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (accept_s),
    .commit_i (last_s),
    .wptr_i   (wptr_q),
    .wdata_i  (pwdata),
    .col_i    (col_count),
    .byte_o   (byte_s)
  );

  assign load_done  = load_done_q;
  assign elem_out   = elem_out_q;
  assign elem_valid = elem_valid_q;
  assign wr_drop    = wr_drop_q;
  assign fill_level = fill_level_q;

endmodule

// File: tb/tb_data_loader.sv
// Directed bench for data_loader: a vector table for the basic load and fetch sweep,
// plus hand sequences for drops, paused fills, overlapping refill and mid-fill reset.
module tb_data_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0, alu_en = 1'b0;
  logic [4:0]  col_count = 5'd0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic        load_done, elem_valid, wr_drop;
  logic [7:0]  elem_out;
  logic [3:0]  fill_level;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        le;
    logic        ae;
    logic [4:0]  col;
    logic        wr;
    logic [31:0] wdata;
    logic        exp_done;
    logic        exp_valid;
    logic        exp_drop;
    logic [7:0]  exp_elem;
    logic [3:0]  exp_level;
  } vec_t;

  vec_t tbl [39];

  data_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .alu_en     (alu_en),
    .col_count  (col_count),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .load_done  (load_done),
    .elem_out   (elem_out),
    .elem_valid (elem_valid),
    .wr_drop    (wr_drop),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic le, input logic ae, input logic [4:0] col,
                       input logic wr, input logic [31:0] d);
    load_en = le; alu_en = ae; col_count = col;
    psel = wr; penable = wr; pwrite = wr; pwdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int base, input int k);
    word_of = {8'(base + 4*k + 3), 8'(base + 4*k + 2), 8'(base + 4*k + 1), 8'(base + 4*k)};
  endfunction

  initial begin
    // Table: 8-word load, idle cycle, col sweep 0..28, then alu_en low.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 5'd0, 1'b1, word_of(0, i), (i == 7), 1'b0, 1'b0, 8'h00,
                 (i == 7) ? 4'd8 : 4'(i + 1)};
    tbl[8] = '{1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
    for (int c = 0; c <= 28; c++)
      tbl[9 + c] = '{1'b0, 1'b1, 5'(c), 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'(c), 4'd0};
    tbl[38] = '{1'b0, 1'b0, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h1C, 4'd0};

    #12;
    chk("reset_done",  {31'd0, load_done},  32'd0);
    chk("reset_elem",  {24'd0, elem_out},   32'd0);
    chk("reset_valid", {31'd0, elem_valid}, 32'd0);
    chk("reset_drop",  {31'd0, wr_drop},    32'd0);
    chk("reset_level", {28'd0, fill_level}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 39; i++) begin
      drive(tbl[i].le, tbl[i].ae, tbl[i].col, tbl[i].wr, tbl[i].wdata);
      tick();
      chk($sformatf("tbl%0d_done", i),  {31'd0, load_done},  {31'd0, tbl[i].exp_done});
      chk($sformatf("tbl%0d_valid", i), {31'd0, elem_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_drop", i),  {31'd0, wr_drop},    {31'd0, tbl[i].exp_drop});
      chk($sformatf("tbl%0d_elem", i),  {24'd0, elem_out},   {24'd0, tbl[i].exp_elem});
      chk($sformatf("tbl%0d_level", i), {28'd0, fill_level}, {28'd0, tbl[i].exp_level});
    end

    // Write with load_en low is dropped.
    drive(1'b0, 1'b0, 5'd0, 1'b1, 32'hDEADBEEF);
    tick();
    chk("drop_pulse", {31'd0, wr_drop},    32'd1);
    chk("drop_level", {28'd0, fill_level}, 32'd0);
    chk("drop_done",  {31'd0, load_done},  32'd0);
    drive(1'b0, 1'b1, 5'd3, 1'b0, 32'h0);
    tick();
    chk("drop_clear", {31'd0, wr_drop},   32'd0);
    chk("drop_keep",  {24'd0, elem_out},  32'h03);

    // 5 words, 10-cycle pause, 3 more words.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1, word_of(8'h40, k));
      tick();
      chk($sformatf("pause_w%0d_done", k), {31'd0, load_done}, 32'd0);
    end
    chk("pause_level5", {28'd0, fill_level}, 32'd5);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
      tick();
      chk($sformatf("pause_idle%0d_done", k), {31'd0, load_done}, 32'd0);
    end
    chk("pause_level_held", {28'd0, fill_level}, 32'd5);
    for (int k = 5; k < 8; k++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1, word_of(8'h40, k));
      tick();
      chk($sformatf("resume_w%0d_done", k), {31'd0, load_done}, {31'd0, (k == 7)});
    end
    chk("resume_level", {28'd0, fill_level}, 32'd8);
    // A write in the COMMIT cycle is dropped despite load_en.
    drive(1'b1, 1'b0, 5'd0, 1'b1, 32'h12345678);
    tick();
    chk("commit_drop",  {31'd0, wr_drop},    32'd1);
    chk("commit_level", {28'd0, fill_level}, 32'd0);
    chk("commit_done",  {31'd0, load_done},  32'd0);
    for (int c = 0; c < 32; c++) begin
      drive(1'b0, 1'b1, 5'(c), 1'b0, 32'h0);
      tick();
      chk($sformatf("resume_col%0d", c), {24'd0, elem_out}, 32'h40 + c);
    end

    // Refill with 0xFFFFFFFF during a sweep: old data until commit.
    for (int j = 0; j < 10; j++) begin
      drive(j < 8, 1'b1, 5'(j), j < 8, 32'hFFFFFFFF);
      tick();
      chk($sformatf("ovl%0d_elem", j), {24'd0, elem_out}, (j < 8) ? 32'h40 + j : 32'hFF);
      chk($sformatf("ovl%0d_done", j), {31'd0, load_done}, {31'd0, (j == 7)});
    end

    // Reset after word 6, then a clean 8-word fill.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 5'd1, 1'b1, 32'h5A5A5A5A);
      tick();
    end
    chk("prerst_valid", {31'd0, elem_valid}, 32'd1);
    chk("prerst_level", {28'd0, fill_level}, 32'd6);
    #2 rst = 1'b0;
    #1;
    chk("rst_elem",  {24'd0, elem_out},   32'd0);
    chk("rst_valid", {31'd0, elem_valid}, 32'd0);
    chk("rst_level", {28'd0, fill_level}, 32'd0);
    chk("rst_done",  {31'd0, load_done},  32'd0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    drive(1'b0, 1'b1, 5'd0, 1'b0, 32'h0);
    tick();
    chk("rst_active_zero", {24'd0, elem_out}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1, word_of(8'h80, k));
      tick();
      chk($sformatf("post_w%0d_done", k), {31'd0, load_done}, {31'd0, (k == 7)});
    end
    for (int c = 0; c < 32; c++) begin
      drive(1'b0, 1'b1, 5'(c), 1'b0, 32'h0);
      tick();
      chk($sformatf("post_col%0d", c), {24'd0, elem_out}, 32'h80 + c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_loader.md
Name: data_loader

Overview:
- Upstream operand stage for the matrix-multiply datapath; sits between the APB-style write bus and the ALU.
- Captures one operand vector of NUM_WORDS 32-bit words while the controller holds load_en high, and double-buffers it.
- Pulses load_done to the controller when the vector is complete.
- During calculation, presents one byte per cycle to the ALU, selected by the controller's col_count.

Parameters:
- NUM_WORDS, 8, words per operand vector (bytes = 4*NUM_WORDS = 32; must be >= 29 so col_count 0..28 is covered)
- WORD_W, 32, bus data width
- ELEM_W, 8, ALU element width (WORD_W/ELEM_W = 4 bytes per word)
- PTR_W, 3, width of word write pointer (clog2 NUM_WORDS)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- load_en  in  1  from controller; fill window open
- alu_en  in  1  from controller ALU_en; element fetch enable
- col_count  in  5  from controller; byte index into active buffer
- psel  in  1  bus select
- penable  in  1  bus access phase
- pwrite  in  1  bus write strobe
- pwdata  in  WORD_W  bus write data
- load_done  out  1  one-cycle pulse: vector complete and committed
- elem_out  out  ELEM_W  registered operand byte to ALU
- elem_valid  out  1  elem_out valid (alu_en delayed one cycle)
- wr_drop  out  1  one-cycle pulse: write attempted while load_en low
- fill_level  out  PTR_W+1  words captured in fill buffer

Behaviour:
- Reset (rst low, async): wptr=0; fill and active buffers cleared to 0; state=IDLE; load_done, elem_out, elem_valid, wr_drop and fill_level all 0.
- Accepted write: psel & penable & pwrite & load_en on a rising edge. Writes fill_buf[wptr] <= pwdata, then wptr+1.
- Dropped write: psel & penable & pwrite with load_en low. Fill buffer unchanged; wr_drop=1 the next cycle.
- FSM states: IDLE, FILL, COMMIT.
  - IDLE -> FILL when load_en=1.
  - FILL -> COMMIT on the accepted write with wptr==NUM_WORDS-1.
  - FILL -> IDLE when load_en falls before completion. wptr is retained, so the fill resumes where it stopped on the next load_en.
  - COMMIT -> IDLE unconditionally after 1 cycle.
- COMMIT cycle:
  - load_done=1, registered: high exactly the cycle after the last word is accepted.
  - active_buf <= fill_buf, with the final word written through in the same edge.
  - wptr <= 0.
  - Bus writes arriving in COMMIT are dropped (wr_drop pulses) even if load_en is still high.
- load_done is never high for more than 1 cycle and is never high in IDLE/FILL.
- fill_level = wptr; reads NUM_WORDS only in COMMIT.
- Byte mapping: byte k = active_buf[k/4][8*(k%4)+7 : 8*(k%4)] (little-endian within word).
- Fetch:
  - When alu_en=1: elem_out <= byte[col_count] on the next edge; elem_valid <= alu_en every cycle.
  - Latency is 1 cycle; elem_out holds its value when alu_en=0.
  - col_count >= 4*NUM_WORDS returns 0.
- Active buffer changes only in COMMIT, so a new fill overlapping calculation never disturbs elem_out.
- A COMMIT coinciding with alu_en=1 uses the pre-commit active_buf for that fetch (read-before-write).
- Reset mid-fill or mid-fetch: everything returns to reset values; the partial vector is discarded.

Decomposition:
- Shared package:
  - loader state encoding (IDLE/FILL/COMMIT)
  - NUM_WORDS, ELEM_W and WORD_W defaults
  - COL_LAST=28, common with the controller's tot_times/row_finish compare
- One natural sub-module: loader_regbank (fill + active buffers, commit copy, byte-select mux). The FSM, pointer and bus decode stay in the top.

Test Plan:
- Reset, load_en=1, 8 writes 0x03020100, 0x07060504 … 0x1F1E1D1C on consecutive cycles -> load_done pulses once, the cycle after word 8; fill_level returns to 0.
- After that load, alu_en=1 with col_count sweeping 0..28 -> elem_out = 0x00..0x1C, each one cycle after its index; elem_valid tracks alu_en delayed 1.
- Write with load_en=0 -> wr_drop=1 next cycle; fill_level unchanged; no load_done.
- 5 words, load_en drops for 10 cycles, then 3 more words -> load_done after the 8th word; active data matches all 8 words in order.
- Second fill of 0xFFFFFFFF words during an alu_en sweep -> elem_out keeps the old vector until the commit cycle, then 0xFF.
- Assert rst low after word 6 -> outputs 0 asynchronously; a subsequent 8-word fill completes normally, with no stale words.
